fetch_stage: RTL and testbench



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 23 ++
 rtl/pc_reg.sv | 27 ++
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage: FSM states, IF/ID field layout, NOP word.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HELD  = 2'd2
  } fetch_state_t;

  localparam int IFID_INSTR_MSB = 63;
  localparam int IFID_INSTR_LSB = 32;
  localparam int IFID_PC_MSB    = 31;
  localparam int IFID_PC_LSB    = 0;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake: single-cycle request pulse out, one-cycle valid pulse back.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter: load redirect target beats increment beats hold; pc_plus4 is combinational.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // 32-bit modulo: 32'hFFFF_FFFC wraps to 0
  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, one-outstanding imem request, IF/ID register; 2 cycles per instruction, pcHOLD freezes PC and IF/ID.
// Optional FETCH_PERF_CNT_EN adds fetch/stall/flush counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pcHOLD,
  input  logic                 BranchControlSignal,
  input  logic [31:0]          BranchTarget,
  fetch_stage_if.master        imem,
  output logic [63:0]          IFIDReg,
  output logic                 IFIDValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_cnt,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  import fetch_pkg::*;

  fetch_state_t state;
  logic         drop;
  logic [31:0]  holdbuf;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         redirect;
  logic         capture_mem;
  logic         release_held;
  logic         advance;

  // A branch seen during a stall is re-evaluated by decode later, so it is ignored here.
  assign redirect     = BranchControlSignal & ~pcHOLD;
  assign capture_mem  = (state == S_WAIT) & imem.imem_valid & ~drop & ~pcHOLD & ~redirect;
  assign release_held = (state == S_HELD) & ~pcHOLD & ~redirect;
  assign advance      = capture_mem | release_held;

  assign imem.imem_req  = (state == S_ISSUE);
  assign imem.imem_addr = pc;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect),
    .inc      (advance),
    .target   (BranchTarget),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ISSUE;
      drop      <= 1'b0;
      holdbuf   <= 32'h0;
      IFIDReg   <= {NOP_INSTR, 32'h0};
      IFIDValid <= 1'b0;
    end else if (redirect) begin
      IFIDReg[IFID_INSTR_MSB:IFID_INSTR_LSB] <= NOP_INSTR;
      IFIDReg[IFID_PC_MSB:IFID_PC_LSB]       <= BranchTarget;
      IFIDValid                              <= 1'b0;
      case (state)
        // The request still goes out at the old PC, so its answer must be thrown away.
        S_ISSUE: begin
          drop  <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_valid) begin
            drop  <= 1'b0;
            state <= S_ISSUE;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: state <= S_ISSUE;
      endcase
    end else begin
      case (state)
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (imem.imem_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_ISSUE;
            end else if (pcHOLD) begin
              holdbuf <= imem.imem_rdata;
              state   <= S_HELD;
            end else begin
              IFIDReg[IFID_INSTR_MSB:IFID_INSTR_LSB] <= imem.imem_rdata;
              IFIDReg[IFID_PC_MSB:IFID_PC_LSB]       <= pc_plus4;
              IFIDValid                              <= 1'b1;
              state                                  <= S_ISSUE;
            end
          end else if (!pcHOLD) begin
            IFIDReg[IFID_INSTR_MSB:IFID_INSTR_LSB] <= NOP_INSTR;
            IFIDReg[IFID_PC_MSB:IFID_PC_LSB]       <= pc_plus4;
            IFIDValid                              <= 1'b0;
          end
        end
        S_HELD: begin
          if (!pcHOLD) begin
            IFIDReg[IFID_INSTR_MSB:IFID_INSTR_LSB] <= holdbuf;
            IFIDReg[IFID_PC_MSB:IFID_PC_LSB]       <= pc_plus4;
            IFIDValid                              <= 1'b1;
            state                                  <= S_ISSUE;
          end
        end
        default: state <= S_ISSUE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (advance)  fetch_cnt <= fetch_cnt + 32'd1;
      if (pcHOLD)   stall_cnt <= stall_cnt + 32'd1;
      if (redirect) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory answers addr ^ 32'h2002_0005 one cycle after each request.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        pcHOLD;
  logic        BranchControlSignal;
  logic [31:0] BranchTarget;
  logic [63:0] IFIDReg;
  logic        IFIDValid;
  logic        mem_en;
  int          vecs;
  int          errs;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  fetch_stage_if imem_bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pcHOLD              (pcHOLD),
    .BranchControlSignal (BranchControlSignal),
    .BranchTarget        (BranchTarget),
    .imem                (imem_bus),
    .IFIDReg             (IFIDReg),
    .IFIDValid           (IFIDValid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt           (fetch_cnt),
    .stall_cnt           (stall_cnt),
    .flush_cnt           (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; memory responds in the next cycle to a request seen in this one.
  task automatic cycle();
    logic        req_now;
    logic [31:0] addr_now;
    req_now  = imem_bus.imem_req && !rst && mem_en;
    addr_now = imem_bus.imem_addr;
    @(posedge clk); #1;
    imem_bus.imem_valid = req_now;
    imem_bus.imem_rdata = req_now ? (addr_now ^ 32'h2002_0005) : 32'h0;
  endtask

  task automatic late_resp(input logic [31:0] w);
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = w;
    @(posedge clk); #1;
    imem_bus.imem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pcHOLD = 1'b0; BranchControlSignal = 1'b0; BranchTarget = 32'h0; mem_en = 1'b1;
    imem_bus.imem_valid = 1'b0; imem_bus.imem_rdata = 32'h0;
    repeat (2) @(posedge clk); #1;
    vecs++; if (IFIDReg !== 64'h0) begin errs++; $display("FAIL reset_ifid: got %h expected %h", IFIDReg, 64'h0); end
    vecs++; if (IFIDValid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", IFIDValid); end
    vecs++; if (imem_bus.imem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr: got %h expected 0", imem_bus.imem_addr); end
    rst = 1'b0;
    cycle();
    vecs++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL first_wait_req: got %b expected 0", imem_bus.imem_req); end
    cycle();
    vecs++; if (IFIDReg !== 64'h2002_0005_0000_0004) begin errs++; $display("FAIL first_ifid: got %h expected %h", IFIDReg, 64'h2002_0005_0000_0004); end
    vecs++; if (IFIDValid !== 1'b1) begin errs++; $display("FAIL first_valid: got %b expected 1", IFIDValid); end
    vecs++; if (imem_bus.imem_addr !== 32'h4 || imem_bus.imem_req !== 1'b1) begin errs++; $display("FAIL first_next_req: addr %h req %b expected 4/1", imem_bus.imem_addr, imem_bus.imem_req); end
  endtask

  task automatic test_back_to_back();
    cycle(); cycle();
    vecs++; if (IFIDReg !== 64'h2002_0001_0000_0008) begin errs++; $display("FAIL b2b_ifid0: got %h expected %h", IFIDReg, 64'h2002_0001_0000_0008); end
    cycle(); cycle();
    vecs++; if (IFIDReg !== 64'h2002_000D_0000_000C) begin errs++; $display("FAIL b2b_ifid1: got %h expected %h", IFIDReg, 64'h2002_000D_0000_000C); end
    vecs++; if (imem_bus.imem_addr !== 32'hC) begin errs++; $display("FAIL b2b_addr: got %h expected c", imem_bus.imem_addr); end
  endtask

  task automatic test_load_use_stall();
    cycle();
    pcHOLD = 1'b1;
    cycle();
    vecs++; if (IFIDReg !== 64'h2002_000D_0000_000C) begin errs++; $display("FAIL hold_ifid0: got %h expected %h", IFIDReg, 64'h2002_000D_0000_000C); end
    vecs++; if (imem_bus.imem_addr !== 32'hC || imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL hold_pc0: addr %h req %b expected c/0", imem_bus.imem_addr, imem_bus.imem_req); end
    cycle();
    vecs++; if (IFIDReg !== 64'h2002_000D_0000_000C || IFIDValid !== 1'b1) begin errs++; $display("FAIL hold_ifid1: got %h/%b expected %h/1", IFIDReg, IFIDValid, 64'h2002_000D_0000_000C); end
    vecs++; if (imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL hold_reissue: got req %b expected 0", imem_bus.imem_req); end
    pcHOLD = 1'b0;
    cycle();
    vecs++; if (IFIDReg !== 64'h2002_0009_0000_0010 || IFIDValid !== 1'b1) begin errs++; $display("FAIL hold_release: got %h/%b expected %h/1", IFIDReg, IFIDValid, 64'h2002_0009_0000_0010); end
    vecs++; if (imem_bus.imem_addr !== 32'h10) begin errs++; $display("FAIL hold_next_addr: got %h expected 10", imem_bus.imem_addr); end
  endtask

  task automatic test_branch_wait();
    mem_en = 1'b0;
    cycle();
    BranchControlSignal = 1'b1; BranchTarget = 32'h40;
    cycle();
    BranchControlSignal = 1'b0;
    vecs++; if (IFIDReg !== 64'h0000_0000_0000_0040 || IFIDValid !== 1'b0) begin errs++; $display("FAIL br_flush: got %h/%b expected %h/0", IFIDReg, IFIDValid, 64'h40); end
    vecs++; if (imem_bus.imem_addr !== 32'h40 || imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL br_outstanding: addr %h req %b expected 40/0", imem_bus.imem_addr, imem_bus.imem_req); end
    late_resp(32'h2002_0015);
    vecs++; if (IFIDReg !== 64'h0000_0000_0000_0040 || IFIDValid !== 1'b0) begin errs++; $display("FAIL br_drop: got %h/%b expected %h/0", IFIDReg, IFIDValid, 64'h40); end
    vecs++; if (imem_bus.imem_addr !== 32'h40 || imem_bus.imem_req !== 1'b1) begin errs++; $display("FAIL br_new_req: addr %h req %b expected 40/1", imem_bus.imem_addr, imem_bus.imem_req); end
    mem_en = 1'b1;
    cycle(); cycle();
    vecs++; if (IFIDReg !== 64'h2002_0045_0000_0044 || IFIDValid !== 1'b1) begin errs++; $display("FAIL br_target_fetch: got %h/%b expected %h/1", IFIDReg, IFIDValid, 64'h2002_0045_0000_0044); end
  endtask

  task automatic test_bubble();
    mem_en = 1'b0;
    cycle(); cycle();
    vecs++; if (IFIDReg !== 64'h0000_0000_0000_0048 || IFIDValid !== 1'b0) begin errs++; $display("FAIL bubble: got %h/%b expected %h/0", IFIDReg, IFIDValid, 64'h48); end
    late_resp(32'h2002_0041);
    vecs++; if (IFIDReg !== 64'h2002_0041_0000_0048 || IFIDValid !== 1'b1) begin errs++; $display("FAIL bubble_late: got %h/%b expected %h/1", IFIDReg, IFIDValid, 64'h2002_0041_0000_0048); end
    mem_en = 1'b1;
  endtask

  task automatic test_branch_hold();
    cycle();
    pcHOLD = 1'b1; BranchControlSignal = 1'b1; BranchTarget = 32'h100;
    cycle();
    vecs++; if (imem_bus.imem_addr !== 32'h48 || IFIDReg !== 64'h2002_0041_0000_0048) begin errs++; $display("FAIL brhold_0: addr %h ifid %h expected 48/%h", imem_bus.imem_addr, IFIDReg, 64'h2002_0041_0000_0048); end
    cycle();
    vecs++; if (imem_bus.imem_addr !== 32'h48 || IFIDValid !== 1'b1) begin errs++; $display("FAIL brhold_1: addr %h valid %b expected 48/1", imem_bus.imem_addr, IFIDValid); end
    pcHOLD = 1'b0; BranchControlSignal = 1'b0;
    cycle();
    vecs++; if (IFIDReg !== 64'h2002_004D_0000_004C || imem_bus.imem_addr !== 32'h4C) begin errs++; $display("FAIL brhold_release: ifid %h addr %h expected %h/4c", IFIDReg, imem_bus.imem_addr, 64'h2002_004D_0000_004C); end
  endtask

  task automatic test_wrap();
    BranchControlSignal = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    cycle();
    BranchControlSignal = 1'b0;
    vecs++; if (IFIDReg !== 64'h0000_0000_FFFF_FFFC || imem_bus.imem_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_redirect: ifid %h addr %h expected %h/fffffffc", IFIDReg, imem_bus.imem_addr, 64'hFFFF_FFFC); end
    cycle();
    vecs++; if (imem_bus.imem_req !== 1'b1 || IFIDValid !== 1'b0) begin errs++; $display("FAIL wrap_drop: req %b valid %b expected 1/0", imem_bus.imem_req, IFIDValid); end
    cycle(); cycle();
    vecs++; if (IFIDReg !== 64'hDFFD_FFF9_0000_0000 || IFIDValid !== 1'b1) begin errs++; $display("FAIL wrap_ifid: got %h/%b expected %h/1", IFIDReg, IFIDValid, 64'hDFFD_FFF9_0000_0000); end
    vecs++; if (imem_bus.imem_addr !== 32'h0) begin errs++; $display("FAIL wrap_addr: got %h expected 0", imem_bus.imem_addr); end
  endtask

  task automatic test_mid_reset();
    cycle(); cycle();
    vecs++; if (imem_bus.imem_addr !== 32'h4) begin errs++; $display("FAIL mrst_pre: got %h expected 4", imem_bus.imem_addr); end
    mem_en = 1'b0;
    cycle();
    rst = 1'b1;
    #2;
    vecs++; if (imem_bus.imem_addr !== 32'h0 || IFIDValid !== 1'b0 || IFIDReg !== 64'h0) begin errs++; $display("FAIL mrst_async: addr %h valid %b ifid %h expected 0/0/0", imem_bus.imem_addr, IFIDValid, IFIDReg); end
    #2;
    rst = 1'b0;
    imem_bus.imem_valid = 1'b1; imem_bus.imem_rdata = 32'hBAD0_0BAD;
    @(posedge clk); #1;
    imem_bus.imem_valid = 1'b0;
    vecs++; if (IFIDValid !== 1'b0 || IFIDReg !== 64'h0 || imem_bus.imem_req !== 1'b0) begin errs++; $display("FAIL mrst_stale: valid %b ifid %h req %b expected 0/0/0", IFIDValid, IFIDReg, imem_bus.imem_req); end
    late_resp(32'h2002_0005);
    vecs++; if (IFIDReg !== 64'h2002_0005_0000_0004 || imem_bus.imem_addr !== 32'h4) begin errs++; $display("FAIL mrst_refetch: ifid %h addr %h expected %h/4", IFIDReg, imem_bus.imem_addr, 64'h2002_0005_0000_0004); end
    mem_en = 1'b1;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    imem_bus.imem_valid = 1'b0;
    mem_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle(); cycle();
    end
    cycle();
    pcHOLD = 1'b1;
    cycle(); cycle(); cycle();
    pcHOLD = 1'b0;
    cycle();
    mem_en = 1'b0;
    cycle();
    BranchControlSignal = 1'b1; BranchTarget = 32'h80;
    cycle(); cycle();
    BranchControlSignal = 1'b0;
    vecs++; if (fetch_cnt !== 32'd10) begin errs++; $display("FAIL perf_fetch: got %0d expected 10", fetch_cnt); end
    vecs++; if (stall_cnt !== 32'd3) begin errs++; $display("FAIL perf_stall: got %0d expected 3", stall_cnt); end
    vecs++; if (flush_cnt !== 32'd2) begin errs++; $display("FAIL perf_flush: got %0d expected 2", flush_cnt); end
    mem_en = 1'b1;
  endtask
`endif

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_back_to_back();
    test_load_use_stall();
    test_branch_wait();
    test_bubble();
    test_branch_hold();
    test_wrap();
    test_mid_reset();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
